// File: rtl/ram_bus_pkg.sv
// ram_bus_pkg: shared types and constants for the ram_bus block.
//   state_t  - bus FSM states
//   WAIT_W   - width of the wait-state counter (supports 0..15 wait states)
//   lanes()  - number of byte lanes in a word of the given bit width
package ram_bus_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        WAIT,
        ACK,
        HOLD
    } state_t;

    localparam int WAIT_W = 4;

    function automatic int lanes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/ram_bus_core.sv
// ram_bus_core: single-port block RAM with per-byte-lane write enables.
//   clk     - clock
//   i_en    - access enable
//   i_we    - 1 = write lanes selected by i_be, 0 = read
//   i_be    - byte-lane write enables
//   i_addr  - word address
//   i_din   - write data
//   o_q     - registered read data; only changes on a read access
module ram_bus_core #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8192,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LANES      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [LANES-1:0]      i_be,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_q
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (i_be[i]) begin
                        r_mem[i_addr][8*i +: 8] <= i_din[8*i +: 8];
                    end
                end
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ram_bus.sv
// ram_bus: byte-lane block RAM behind a request/acknowledge bus handshake,
// with programmable wait states and an optional zero-fill sweep after reset.
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   req    - access request, held by the requester until it sees ack
//   we     - 1 = write, 0 = read (sampled on accept)
//   mask   - byte-lane enables for writes (sampled on accept)
//   addr   - word address (sampled on accept)
//   din    - write data (sampled on accept)
//   dout   - read data, valid with ack and held until the next read completes
//   ack    - one-cycle completion pulse
//   busy   - high during the clear sweep and from accept until req is released
module ram_bus
    import ram_bus_pkg::*;
#(
    parameter int  DATA_WIDTH     = 16,
    parameter int  DEPTH          = 8192,
    parameter int  ADDR_WIDTH     = $clog2(DEPTH),
    parameter int  WAIT_STATES    = 0,
    parameter bit  CLEAR_ON_RESET = 1'b1,
    localparam int LANES          = lanes(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [LANES-1:0]      mask,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  ack,
    output logic                  busy
);

    localparam logic [WAIT_W-1:0]     WAIT_LOAD = WAIT_W'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                r_state;
    logic [WAIT_W-1:0]     r_wait;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  r_we;
    logic [LANES-1:0]      r_mask;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_ack;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_dout;

    logic                  w_issue;
    logic                  w_in_range;
    logic                  w_ram_en;
    logic                  w_ram_we;
    logic [LANES-1:0]      w_ram_be;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_din;
    logic [DATA_WIDTH-1:0] w_ram_q;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_rd_ack;

    assign w_issue    = (r_state == WAIT) && (r_wait == '0);
    // Only matters when DEPTH is not a power of two.
    assign w_in_range = ({1'b0, r_addr} < DEPTH_L);

    // RAM port mux: the clear sweep owns the port in CLEAR, the latched
    // bus request owns it on the issue cycle. Out-of-range accesses never
    // reach the array. Held off during reset so an aborted write is dropped.
    always_comb begin
        w_ram_en   = 1'b0;
        w_ram_we   = 1'b0;
        w_ram_be   = '0;
        w_ram_addr = r_addr;
        w_ram_din  = r_din;
        if (!reset) begin
            if (r_state == CLEAR) begin
                w_ram_en   = 1'b1;
                w_ram_we   = 1'b1;
                w_ram_be   = '1;
                w_ram_addr = r_clr_addr;
                w_ram_din  = '0;
            end else if (w_issue && w_in_range) begin
                w_ram_en = 1'b1;
                w_ram_we = r_we;
                w_ram_be = r_mask;
            end
        end
    end

    ram_bus_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANES      (LANES)
    ) u_core (
        .clk    (clk),
        .i_en   (w_ram_en),
        .i_we   (w_ram_we),
        .i_be   (w_ram_be),
        .i_addr (w_ram_addr),
        .i_din  (w_ram_din),
        .o_q    (w_ram_q)
    );

    // The RAM output register lands on the same edge as ack, so during the
    // ACK cycle of a read the fresh RAM word is presented directly; r_dout
    // captures it so dout holds until the next read completes.
    assign w_rd_data = w_in_range ? w_ram_q : '0;
    assign w_rd_ack  = (r_state == ACK) && !r_we;
    assign dout      = w_rd_ack ? w_rd_data : r_dout;
    assign ack       = r_ack;
    assign busy      = r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= CLEAR_ON_RESET ? CLEAR : IDLE;
            r_wait     <= '0;
            r_clr_addr <= '0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b1;
            r_dout     <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == LAST_ADDR) begin
                        r_clr_addr <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                IDLE: begin
                    r_busy <= 1'b0;
                    if (req) begin
                        r_we    <= we;
                        r_mask  <= mask;
                        r_addr  <= addr;
                        r_din   <= din;
                        r_wait  <= WAIT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_wait == '0) begin
                        r_ack   <= 1'b1;
                        r_state <= ACK;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= HOLD;
                    if (!r_we) begin
                        r_dout <= w_rd_data;
                    end
                end
                HOLD: begin
                    if (!req) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus.sv
module tb_ram_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  mask;
    logic [3:0]  addr;
    logic [15:0] din;
    int          sel;

    logic [2:0]  req_v;
    logic [2:0]  ack_v;
    logic [2:0]  busy_v;
    logic [15:0] dout_v [3];

    always #5 clk = ~clk;

    assign req_v = {req && (sel == 2), req && (sel == 1), req && (sel == 0)};

    // Instance 0: no wait states, cleared. Instance 1: 3 wait states, cleared.
    // Instance 2: 2 wait states, not cleared, non-power-of-two depth.
    ram_bus #(.DATA_WIDTH(16), .DEPTH(16), .WAIT_STATES(0), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .reset(rst), .req(req_v[0]), .we(we), .mask(mask), .addr(addr),
        .din(din), .dout(dout_v[0]), .ack(ack_v[0]), .busy(busy_v[0]));
    ram_bus #(.DATA_WIDTH(16), .DEPTH(16), .WAIT_STATES(3), .CLEAR_ON_RESET(1'b1)) u_b (
        .clk(clk), .reset(rst), .req(req_v[1]), .we(we), .mask(mask), .addr(addr),
        .din(din), .dout(dout_v[1]), .ack(ack_v[1]), .busy(busy_v[1]));
    ram_bus #(.DATA_WIDTH(16), .DEPTH(12), .WAIT_STATES(2), .CLEAR_ON_RESET(1'b0)) u_c (
        .clk(clk), .reset(rst), .req(req_v[2]), .we(we), .mask(mask), .addr(addr),
        .din(din), .dout(dout_v[2]), .ack(ack_v[2]), .busy(busy_v[2]));

    int          ws_c  [3];
    int          dep_c [3];
    bit          clr_c [3];
    logic [15:0] mdl     [3][16];
    logic [15:0] last_rd [3];
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          d;
        bit          w;
        logic [1:0]  m;
        logic [3:0]  a;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            last_rd[d] = 16'h0000;
            if (clr_c[d]) begin
                for (int a = 0; a < 16; a++) mdl[d][a] = 16'h0000;
            end
        end
    endtask

    // One complete bus transaction on instance d, checked against the model.
    task automatic access(input int d, input bit w, input logic [1:0] m, input logic [3:0] a,
                          input logic [15:0] data, input int hold, output logic [15:0] rd);
        int n;
        int acks;
        bit seen;
        logic [15:0] exp;
        n = 0;
        while (busy_v[d] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_before_req", busy_v[d], 0);
        sel = d; we = w; mask = m; addr = a; din = data; req = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (ack_v[d] === 1'b1) seen = 1'b1;
        end
        chk("ack_latency", n, 2 + ws_c[d]);
        if (w) exp = last_rd[d];
        else   exp = (int'(a) < dep_c[d]) ? mdl[d][a] : 16'h0000;
        chk(w ? "dout_kept_on_write" : "read_data", dout_v[d], exp);
        rd = dout_v[d];
        if (w) begin
            if (int'(a) < dep_c[d]) begin
                if (m[0]) mdl[d][a][7:0]  = data[7:0];
                if (m[1]) mdl[d][a][15:8] = data[15:8];
            end
        end else begin
            last_rd[d] = exp;
        end
        acks = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("busy_while_held", busy_v[d], 1);
            if (ack_v[d] !== 1'b0) acks++;
        end
        req = 1'b0;
        n = 0;
        while (busy_v[d] !== 1'b0 && n < 6) begin
            @(negedge clk);
            n++;
            if (ack_v[d] !== 1'b0) acks++;
        end
        chk("busy_release_lat", n, (hold == 0) ? 2 : 1);
        chk("extra_acks", acks, 0);
        chk("dout_held", dout_v[d], last_rd[d]);
    endtask

    // Start a write on instance d and reset during its wait states.
    task automatic abort_write(input int d, input logic [3:0] a, input logic [15:0] data);
        int n;
        int acks;
        n = 0;
        while (busy_v[d] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        sel = d; we = 1'b1; mask = 2'b11; addr = a; din = data; req = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack_v !== 3'b000) acks++;
        end
        chk("no_ack_on_abort", acks, 0);
        req = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] rd;
        int n;
        ws_c  = '{0, 3, 2};
        dep_c = '{16, 16, 12};
        clr_c = '{1'b1, 1'b1, 1'b0};
        rst = 1'b1; req = 1'b0; we = 1'b0; mask = 2'b00; addr = 4'h0; din = 16'h0000; sel = 0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_ack", ack_v[d], 0);
            chk("reset_dout", dout_v[d], 0);
            chk("reset_busy", busy_v[d], 1);
        end
        rst = 1'b0;
        model_reset();

        // Clear sweep length.
        n = 0;
        while (busy_v[0] !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("clear_len", n, 16);
        for (int a = 0; a < 16; a++) begin
            access(0, 1'b0, 2'b00, 4'(a), 16'h0000, 0, rd);
            chk("cleared_word", rd, 16'h0000);
        end

        // Give the uncleared instance known contents.
        for (int a = 0; a < 12; a++) access(2, 1'b1, 2'b11, 4'(a), 16'hC000 + 16'(a), 0, rd);

        tbl.push_back('{0, 1'b1, 2'b11, 4'd5,  16'hBEEF, 16'h0000});
        tbl.push_back('{0, 1'b0, 2'b00, 4'd5,  16'h0000, 16'hBEEF});
        tbl.push_back('{0, 1'b1, 2'b11, 4'd3,  16'h1234, 16'h0000});
        tbl.push_back('{0, 1'b1, 2'b10, 4'd3,  16'hAB00, 16'h0000});
        tbl.push_back('{0, 1'b0, 2'b00, 4'd3,  16'h0000, 16'hAB34});
        tbl.push_back('{0, 1'b1, 2'b01, 4'd3,  16'h00CD, 16'h0000});
        tbl.push_back('{0, 1'b0, 2'b00, 4'd3,  16'h0000, 16'hABCD});
        tbl.push_back('{0, 1'b1, 2'b00, 4'd3,  16'hFFFF, 16'h0000});
        tbl.push_back('{0, 1'b0, 2'b00, 4'd3,  16'h0000, 16'hABCD});
        tbl.push_back('{2, 1'b1, 2'b11, 4'd13, 16'h7777, 16'h0000});
        tbl.push_back('{2, 1'b0, 2'b00, 4'd13, 16'h0000, 16'h0000});
        tbl.push_back('{2, 1'b0, 2'b00, 4'd11, 16'h0000, 16'hC00B});
        tbl.push_back('{1, 1'b1, 2'b11, 4'd9,  16'h5A5A, 16'h0000});
        tbl.push_back('{1, 1'b0, 2'b00, 4'd9,  16'h0000, 16'h5A5A});
        foreach (tbl[i]) begin
            access(tbl[i].d, tbl[i].w, tbl[i].m, tbl[i].a, tbl[i].data, 0, rd);
            if (!tbl[i].w) chk($sformatf("tbl_read_%0d", i), rd, tbl[i].exp);
        end

        // 3 wait states, req held 10 cycles past ack.
        access(1, 1'b1, 2'b11, 4'd2, 16'h9999, 10, rd);
        access(1, 1'b0, 2'b00, 4'd2, 16'h0000, 10, rd);
        chk("held_req_read", rd, 16'h9999);

        // Request raised during the clear sweep.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        sel = 0; we = 1'b1; mask = 2'b11; addr = 4'd9; din = 16'h4242; req = 1'b1;
        rst = 1'b0;
        n = 0;
        while (ack_v[0] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ack_after_clear", n, 18);
        req = 1'b0;
        mdl[0][9] = 16'h4242;
        access(0, 1'b0, 2'b00, 4'd9, 16'h0000, 0, rd);
        chk("write_during_clear", rd, 16'h4242);

        // Reset in WAIT aborts the write.
        access(1, 1'b1, 2'b11, 4'd7, 16'h1111, 0, rd);
        abort_write(1, 4'd7, 16'h5555);
        access(1, 1'b0, 2'b00, 4'd7, 16'h0000, 0, rd);
        chk("abort_cleared", rd, 16'h0000);
        access(2, 1'b1, 2'b11, 4'd7, 16'h2222, 0, rd);
        abort_write(2, 4'd7, 16'h5555);
        access(2, 1'b0, 2'b00, 4'd7, 16'h0000, 0, rd);
        chk("abort_kept", rd, 16'h2222);

        // Randomized traffic against the model.
        for (int i = 0; i < 250; i++) begin
            access(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 2'($urandom),
                   4'($urandom), 16'($urandom), int'($urandom_range(0, 3)), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
